// File: rtl/operands_dispatch_arb.sv
// rtl/operands_dispatch_arb.sv - round-robin arbiter feeding one registered operand issue slot
// Optional perf counters (perf_stall_cycles, perf_conflict_cycles) under `OPERANDS_ARB_PERF_EN.
module operands_dispatch_arb #(
  parameter int NUM_REQS      = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int REQ_SELW      = 2,
  parameter int PERF_CTR_BITS = 44
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            in_valid,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_REQS-1:0]            in_ready,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [REQ_SELW-1:0]            out_sel,
  input  logic                           out_ready
`ifdef OPERANDS_ARB_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]       perf_stall_cycles,
  output logic [PERF_CTR_BITS-1:0]       perf_conflict_cycles
`endif
);

  logic [REQ_SELW-1:0]   rr_ptr;
  logic [REQ_SELW-1:0]   next_ptr;
  logic [REQ_SELW-1:0]   cand;
  logic [REQ_SELW-1:0]   grant_idx;
  logic [NUM_REQS-1:0]   grant;
  logic                  found;
  logic                  stage_ready;
  logic                  xfer_in;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [DATA_WIDTH-1:0] bank_data [NUM_REQS];

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
    assign bank_data[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan starts at rr_ptr and wraps; the first valid bank wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    sel_data  = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      cand = REQ_SELW'((int'(rr_ptr) + k) % NUM_REQS);
      if (!found && in_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
        sel_data    = bank_data[cand];
      end
    end
  end

  assign stage_ready = !out_valid || out_ready;
  assign in_ready    = grant & {NUM_REQS{stage_ready}};
  assign xfer_in     = found && stage_ready;
  assign next_ptr    = (grant_idx == REQ_SELW'(NUM_REQS-1)) ? '0 : grant_idx + REQ_SELW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (xfer_in) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant_idx;
      rr_ptr    <= next_ptr;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef OPERANDS_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles    <= '0;
      perf_conflict_cycles <= '0;
    end else begin
      if (out_valid && !out_ready)
        perf_stall_cycles <= perf_stall_cycles + PERF_CTR_BITS'(1);
      if (xfer_in && ($countones(in_valid) >= 2))
        perf_conflict_cycles <= perf_conflict_cycles + PERF_CTR_BITS'(1);
    end
  end
`endif

endmodule

// File: tb/tb_operands_dispatch_arb.sv
// tb/tb_operands_dispatch_arb.sv - vector table plus scoreboard bench for operands_dispatch_arb
module tb_operands_dispatch_arb;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   in_valid;
  logic [255:0] in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [63:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_ready;
`ifdef OPERANDS_ARB_PERF_EN
  logic [43:0]  perf_stall_cycles;
  logic [43:0]  perf_conflict_cycles;
`endif

  operands_dispatch_arb dut (
    .clk                  (clk),
    .reset                (reset),
    .in_valid             (in_valid),
    .in_data              (in_data),
    .in_ready             (in_ready),
    .out_valid            (out_valid),
    .out_data             (out_data),
    .out_sel              (out_sel),
    .out_ready            (out_ready)
`ifdef OPERANDS_ARB_PERF_EN
    ,
    .perf_stall_cycles    (perf_stall_cycles),
    .perf_conflict_cycles (perf_conflict_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic       ordy;
    logic [3:0] rdy;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  sel;
  } item_t;

  vec_t  tbl[$];
  item_t q[$];
  int    total = 0;
  int    bad   = 0;
  int    tick  = 0;
  logic  m_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (tick %0d)", name, act, exp, tick);
    end
  endtask

  function automatic logic [63:0] pay(input int b, input int t);
    return 64'hA5A5_0000_0000_0000 | (64'(t) << 8) | 64'(b);
  endfunction

  function automatic logic [1:0] sel_of(input logic [3:0] r);
    for (int i = 0; i < 4; i++)
      if (r[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic void add(input logic [3:0] v, input logic ordy, input logic [3:0] rdy);
    vec_t e;
    e.v = v; e.ordy = ordy; e.rdy = rdy;
    tbl.push_back(e);
  endfunction

  // One cycle: drive, check mid-cycle, update the reference model, advance.
  task automatic step(input logic [3:0] v, input logic ordy, input logic [3:0] rdy);
    item_t it;
    in_valid  = v;
    out_ready = ordy;
    for (int i = 0; i < 4; i++) in_data[i*64 +: 64] = pay(i, tick);
    #4;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid && q.size() > 0) begin
      chk("out_data", out_data, q[0].data);
      chk("out_sel", 64'(out_sel), 64'(q[0].sel));
      if (ordy) void'(q.pop_front());
    end
    if (rdy != 4'b0000) begin
      it.sel  = sel_of(rdy);
      it.data = pay(int'(it.sel), tick);
      q.push_back(it);
    end
    m_valid = (rdy != 4'b0000) || (m_valid && !ordy);
    tick++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sel", 64'(out_sel), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef OPERANDS_ARB_PERF_EN
    chk("rst_perf_stall", 64'(perf_stall_cycles), 64'd0);
    chk("rst_perf_conflict", 64'(perf_conflict_cycles), 64'd0);
`endif
    reset   = 1'b0;
    m_valid = 1'b0;
    q.delete();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;

    // all banks contending: strict rotation
    add(4'b1111, 1, 4'b0001); add(4'b1111, 1, 4'b0010);
    add(4'b1111, 1, 4'b0100); add(4'b1111, 1, 4'b1000);
    add(4'b1111, 1, 4'b0001); add(4'b1111, 1, 4'b0010);
    add(4'b1111, 1, 4'b0100); add(4'b1111, 1, 4'b1000);
    // single bank streaming
    for (int i = 0; i < 5; i++) add(4'b0100, 1, 4'b0100);
    // bank 1 wins, then pointer at 2 wraps to bank 0
    add(4'b0010, 1, 4'b0010); add(4'b0011, 1, 4'b0001);
    // downstream stall then release to rr_ptr bank
    add(4'b1111, 0, 4'b0000); add(4'b1111, 0, 4'b0000); add(4'b1111, 0, 4'b0000);
    add(4'b1111, 1, 4'b0010);
    add(4'b0000, 1, 4'b0000);

    do_reset();
    foreach (tbl[n]) step(tbl[n].v, tbl[n].ordy, tbl[n].rdy);

    // reset while stalled with a pending packet
    step(4'b0100, 0, 4'b0100);
    step(4'b1111, 0, 4'b0000);
    do_reset();
    step(4'b1111, 1, 4'b0001);

    // stall and contention accounting from a clean reset
    do_reset();
    step(4'b0001, 1, 4'b0001);
    step(4'b1111, 0, 4'b0000);
    step(4'b1111, 0, 4'b0000);
    step(4'b1111, 0, 4'b0000);
    step(4'b1111, 1, 4'b0010);
    step(4'b1111, 1, 4'b0100);
    step(4'b1111, 1, 4'b1000);
    step(4'b1111, 1, 4'b0001);
    step(4'b0000, 1, 4'b0000);
`ifdef OPERANDS_ARB_PERF_EN
    chk("perf_stall", 64'(perf_stall_cycles), 64'd3);
    chk("perf_conflict", 64'(perf_conflict_cycles), 64'd4);
`endif
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
